// File: rtl/store_write_buffer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : store_write_buffer_pkg
//  Purpose  : Shared widths and drain/fill arbitration state encodings.
//  Revision : 1.0 - initial release
// ============================================================================
package store_write_buffer_pkg;

    localparam int c_DEPTH  = 4;
    localparam int c_ADDR_W = 16;
    localparam int c_DATA_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_DRAIN = 2'b01,
        ST_FILL  = 2'b10
    } wb_state_e;

endpackage
`default_nettype wire

// File: rtl/store_write_buffer_if.sv
`default_nettype none
// ============================================================================
//  Module   : store_write_buffer_if
//  Purpose  : Store, load-forward, fill-arbitration and memory-write signals.
//  Revision : 1.0 - initial release
// ============================================================================
interface store_write_buffer_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int CNT_W  = 3
);
    logic              st_valid;
    logic [ADDR_W-1:0] st_addr;
    logic [DATA_W-1:0] st_data;
    logic              st_stall;
    logic [ADDR_W-1:0] ld_addr;
    logic              ld_fwd;
    logic [DATA_W-1:0] ld_fwd_data;
    logic              fill_req;
    logic [ADDR_W-1:0] fill_addr;
    logic              fill_gnt;
    logic              fill_done;
    logic              mem_en;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              empty;
    logic [CNT_W-1:0]  count;

    modport slave (
        input  st_valid, st_addr, st_data, ld_addr, fill_req, fill_addr, fill_done,
        output st_stall, ld_fwd, ld_fwd_data, fill_gnt, mem_en, mem_wr,
               mem_addr, mem_data, empty, count
    );

    modport master (
        output st_valid, st_addr, st_data, ld_addr, fill_req, fill_addr, fill_done,
        input  st_stall, ld_fwd, ld_fwd_data, fill_gnt, mem_en, mem_wr,
               mem_addr, mem_data, empty, count
    );
endinterface
`default_nettype wire

// File: rtl/store_write_buffer_match.sv
`default_nettype none
// ============================================================================
//  Module   : wb_match_unit
//  Purpose  : Parallel entry compare for load forwarding, coalescing and
//             fill-block conflict detection.
//  Revision : 1.0 - initial release
// ============================================================================
module wb_match_unit
    import store_write_buffer_pkg::*;
#(
    parameter int DEPTH  = c_DEPTH,
    parameter int ADDR_W = c_ADDR_W,
    parameter int DATA_W = c_DATA_W,
    parameter int PTR_W  = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0]             i_valid,
    input  logic [DEPTH-1:0][ADDR_W-1:0] i_addr,
    input  logic [DEPTH-1:0][DATA_W-1:0] i_data,
    input  logic [PTR_W-1:0]             i_head,
    input  logic                         i_excl_head,
    input  logic [ADDR_W-1:0]            i_ld_addr,
    input  logic [ADDR_W-1:0]            i_st_addr,
    input  logic [ADDR_W-1:0]            i_fill_addr,
    output logic                         o_ld_fwd,
    output logic [DATA_W-1:0]            o_ld_fwd_data,
    output logic                         o_st_hit,
    output logic [PTR_W-1:0]             o_st_idx,
    output logic                         o_fill_conf
);

    logic [PTR_W-1:0] w_idx;
    logic             w_unused;

    assign w_unused = ^{i_ld_addr[0], i_st_addr[0], i_fill_addr[2:0]};

    // Walk entries oldest to youngest so the last hit is the youngest match
    always_comb begin
        o_ld_fwd      = 1'b0;
        o_ld_fwd_data = '0;
        o_st_hit      = 1'b0;
        o_st_idx      = '0;
        o_fill_conf   = 1'b0;
        w_idx         = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = i_head + PTR_W'(i);
            if (i_valid[w_idx] && (i_addr[w_idx][ADDR_W-1:1] == i_ld_addr[ADDR_W-1:1])) begin
                o_ld_fwd      = 1'b1;
                o_ld_fwd_data = i_data[w_idx];
            end
            if (i_valid[w_idx] && (i_addr[w_idx][ADDR_W-1:1] == i_st_addr[ADDR_W-1:1])) begin
                o_st_hit = 1'b1;
                o_st_idx = w_idx;
            end
            if (i_valid[w_idx] && !(i_excl_head && (i == 0)) &&
                (i_addr[w_idx][ADDR_W-1:3] == i_fill_addr[ADDR_W-1:3])) begin
                o_fill_conf = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/store_write_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : store_write_buffer
//  Purpose  : Coalescing store FIFO draining to a shared memory port that is
//             arbitrated against the cache fill FSM.
//  Revision : 1.0 - initial release
// ============================================================================
module store_write_buffer
    import store_write_buffer_pkg::*;
#(
    parameter int DEPTH  = c_DEPTH,
    parameter int ADDR_W = c_ADDR_W,
    parameter int DATA_W = c_DATA_W
) (
    input  logic                 clk,
    input  logic                 rst,
    store_write_buffer_if.slave  sb
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    logic [DEPTH-1:0]             r_valid;
    logic [DEPTH-1:0][ADDR_W-1:0] r_addr;
    logic [DEPTH-1:0][DATA_W-1:0] r_data;
    logic [c_PTR_W-1:0]           r_head;
    logic [c_PTR_W-1:0]           r_tail;
    logic [c_CNT_W-1:0]           r_count;
    wb_state_e                    r_state;
    wb_state_e                    w_state_next;

    logic               w_full, w_empty, w_deq, w_st_acc;
    logic               w_coalesce, w_alloc, w_new_conf, w_fill_ok;
    logic               w_st_hit, w_fill_conf;
    logic [c_PTR_W-1:0] w_st_idx;
    logic [c_CNT_W-1:0] w_cnt_next;

    wb_match_unit #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .PTR_W  (c_PTR_W)
    ) u_match (
        .i_valid       (r_valid),
        .i_addr        (r_addr),
        .i_data        (r_data),
        .i_head        (r_head),
        .i_excl_head   (w_deq),
        .i_ld_addr     (sb.ld_addr),
        .i_st_addr     (sb.st_addr),
        .i_fill_addr   (sb.fill_addr),
        .o_ld_fwd      (sb.ld_fwd),
        .o_ld_fwd_data (sb.ld_fwd_data),
        .o_st_hit      (w_st_hit),
        .o_st_idx      (w_st_idx),
        .o_fill_conf   (w_fill_conf)
    );

    assign w_full     = (r_count == c_CNT_W'(DEPTH));
    assign w_empty    = (r_count == '0);
    assign w_deq      = (r_state == ST_DRAIN) && !w_empty;
    assign w_st_acc   = sb.st_valid && !w_full;
    // The head being written this cycle is already gone; merging into it would lose data
    assign w_coalesce = w_st_acc && w_st_hit && !(w_deq && (w_st_idx == r_head));
    assign w_alloc    = w_st_acc && !w_coalesce;
    assign w_new_conf = w_st_acc && (sb.st_addr[ADDR_W-1:3] == sb.fill_addr[ADDR_W-1:3]);
    assign w_fill_ok  = sb.fill_req && !w_fill_conf && !w_new_conf;
    assign w_cnt_next = r_count + c_CNT_W'(w_alloc) - c_CNT_W'(w_deq);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
            r_addr  <= '0;
            r_data  <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
            r_count <= w_cnt_next;
            if (w_deq) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + 1'b1;
            end
            if (w_alloc) begin
                r_valid[r_tail] <= 1'b1;
                r_addr[r_tail]  <= sb.st_addr;
                r_data[r_tail]  <= sb.st_data;
                r_tail          <= r_tail + 1'b1;
            end
            if (w_coalesce) begin
                r_data[w_st_idx] <= sb.st_data;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_fill_ok)
                    w_state_next = ST_FILL;
                else if (!w_empty)
                    w_state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (w_fill_ok)
                    w_state_next = ST_FILL;
                else if (w_cnt_next == '0)
                    w_state_next = ST_IDLE;
            end
            ST_FILL: begin
                if (sb.fill_done)
                    w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign sb.st_stall = w_full;
    assign sb.fill_gnt = (r_state == ST_FILL);
    assign sb.mem_en   = w_deq;
    assign sb.mem_wr   = w_deq;
    assign sb.mem_addr = w_deq ? r_addr[r_head] : '0;
    assign sb.mem_data = w_deq ? r_data[r_head] : '0;
    assign sb.empty    = w_empty;
    assign sb.count    = r_count;

endmodule
`default_nettype wire

// File: tb/tb_store_write_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_store_write_buffer
//  Purpose  : Directed stimulus with a memory-write scoreboard for the buffer.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_store_write_buffer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    store_write_buffer_if #(.ADDR_W(16), .DATA_W(16), .CNT_W(3)) sb();

    store_write_buffer #(.DEPTH(4), .ADDR_W(16), .DATA_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .sb  (sb)
    );

    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_wr(input logic [15:0] a, input logic [15:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // Scoreboard monitor: every memory write must match the next expected one
    always @(negedge clk) begin : mon
        wr_t e;
        if (sb.mem_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h required none",
                         sb.mem_addr, sb.mem_data);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", 32'(sb.mem_addr), 32'(e.addr));
                check("wr_data", 32'(sb.mem_data), 32'(e.data));
                check("wr_strobe", 32'(sb.mem_wr), 32'd1);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_store(input logic [15:0] a, input logic [15:0] d);
        int t;
        sb.st_valid = 1'b1;
        sb.st_addr  = a;
        sb.st_data  = d;
        t = 0;
        @(negedge clk);
        while (sb.st_stall && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) check("store_timeout", 32'(sb.st_stall), 32'd0);
        @(posedge clk);
        #1;
        sb.st_valid = 1'b0;
    endtask

    task automatic wait_empty(input string name);
        int t;
        t = 0;
        while (!(sb.empty === 1'b1 && sb.mem_en === 1'b0) && t < 50) begin
            tick();
            t++;
        end
        check(name, 32'(sb.empty), 32'd1);
        check({name, "_queue"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic enter_fill(input logic [15:0] fa);
        int t;
        sb.fill_req  = 1'b1;
        sb.fill_addr = fa;
        t = 0;
        while (sb.fill_gnt !== 1'b1 && t < 20) begin
            tick();
            t++;
        end
        check("fill_grant", 32'(sb.fill_gnt), 32'd1);
    endtask

    task automatic release_fill();
        sb.fill_done = 1'b1;
        sb.fill_req  = 1'b0;
        tick();
        sb.fill_done = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int t, w, g;
        sb.st_valid  = 1'b0;
        sb.st_addr   = '0;
        sb.st_data   = '0;
        sb.ld_addr   = 16'hFFFE;
        sb.fill_req  = 1'b0;
        sb.fill_addr = '0;
        sb.fill_done = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_count", 32'(sb.count), 32'd0);
        check("rst_empty", 32'(sb.empty), 32'd1);
        check("rst_stall", 32'(sb.st_stall), 32'd0);
        check("rst_gnt", 32'(sb.fill_gnt), 32'd0);
        check("rst_mem_en", 32'(sb.mem_en), 32'd0);
        check("rst_fwd", 32'(sb.ld_fwd), 32'd0);
        rst = 1'b0;

        // 1: four stores drain in order
        expect_wr(16'h0010, 16'hA010);
        expect_wr(16'h0012, 16'hA012);
        expect_wr(16'h0014, 16'hA014);
        expect_wr(16'h0016, 16'hA016);
        do_store(16'h0010, 16'hA010);
        check("t1_count_first", 32'(sb.count), 32'd1);
        do_store(16'h0012, 16'hA012);
        check("t1_count_second", 32'(sb.count), 32'd2);
        do_store(16'h0014, 16'hA014);
        do_store(16'h0016, 16'hA016);
        wait_empty("t1_empty");

        // 2: buffer full while fill owns memory
        enter_fill(16'h0800);
        for (int i = 0; i < 4; i++) begin
            expect_wr(16'h0100 + 16'(2 * i), 16'h1000 + 16'(i));
            do_store(16'h0100 + 16'(2 * i), 16'h1000 + 16'(i));
        end
        expect_wr(16'h0108, 16'h1004);
        check("t2_count_full", 32'(sb.count), 32'd4);
        sb.st_valid = 1'b1;
        sb.st_addr  = 16'h0108;
        sb.st_data  = 16'h1004;
        @(negedge clk);
        check("t2_stall_full", 32'(sb.st_stall), 32'd1);
        @(posedge clk);
        #1;
        release_fill();
        t = 0;
        @(negedge clk);
        while (sb.st_stall === 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("t2_count_at_accept", 32'(sb.count), 32'd3);
        @(posedge clk);
        #1;
        sb.st_valid = 1'b0;
        wait_empty("t2_empty");

        // 3: back-to-back stores to one word coalesce
        expect_wr(16'h0020, 16'hBBBB);
        do_store(16'h0020, 16'hAAAA);
        do_store(16'h0020, 16'hBBBB);
        check("t3_count_coalesced", 32'(sb.count), 32'd1);
        wait_empty("t3_empty");

        // 4: conflicting fill waits for the block's store to drain
        expect_wr(16'h0040, 16'h1234);
        sb.fill_req  = 1'b1;
        sb.fill_addr = 16'h0042;
        do_store(16'h0040, 16'h1234);
        w = 0;
        g = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (sb.mem_en === 1'b1 && w == 0) w = c;
            if (sb.fill_gnt === 1'b1) begin
                g = c;
                break;
            end
        end
        check("t4_write_seen", 32'(w != 0), 32'd1);
        check("t4_gnt_after_write", 32'(g), 32'(w + 1));
        @(posedge clk);
        #1;
        release_fill();
        wait_empty("t4_empty");

        // 5: forwarding, bit-0 ignored, coalesce while filling, youngest wins
        enter_fill(16'h0800);
        expect_wr(16'h0050, 16'h6666);
        expect_wr(16'h0052, 16'h7777);
        do_store(16'h0050, 16'h5555);
        sb.ld_addr = 16'h0050;
        #1;
        check("t5_fwd_hit", 32'(sb.ld_fwd), 32'd1);
        check("t5_fwd_data", 32'(sb.ld_fwd_data), 32'h5555);
        sb.ld_addr = 16'h0051;
        #1;
        check("t5_fwd_bit0", 32'(sb.ld_fwd), 32'd1);
        sb.ld_addr = 16'h0052;
        #1;
        check("t5_fwd_miss", 32'(sb.ld_fwd), 32'd0);
        check("t5_fwd_miss_data", 32'(sb.ld_fwd_data), 32'd0);
        do_store(16'h0050, 16'h6666);
        check("t5_count_coalesce", 32'(sb.count), 32'd1);
        do_store(16'h0052, 16'h7777);
        sb.ld_addr = 16'h0050;
        #1;
        check("t5_fwd_merged", 32'(sb.ld_fwd_data), 32'h6666);
        sb.ld_addr = 16'h0052;
        #1;
        check("t5_fwd_second", 32'(sb.ld_fwd_data), 32'h7777);
        release_fill();
        wait_empty("t5_empty");

        // 5b: store to the draining head allocates; younger copy forwards
        enter_fill(16'h0800);
        expect_wr(16'h0060, 16'h0001);
        expect_wr(16'h0060, 16'h0002);
        do_store(16'h0060, 16'h0001);
        release_fill();
        t = 0;
        while (sb.mem_en !== 1'b1 && t < 20) begin
            tick();
            t++;
        end
        sb.st_valid = 1'b1;
        sb.st_addr  = 16'h0060;
        sb.st_data  = 16'h0002;
        sb.ld_addr  = 16'h0060;
        @(negedge clk);
        check("t5b_fwd_old_head", 32'(sb.ld_fwd_data), 32'h0001);
        @(posedge clk);
        #1;
        sb.st_valid = 1'b0;
        check("t5b_count_alloc", 32'(sb.count), 32'd1);
        check("t5b_fwd_new", 32'(sb.ld_fwd_data), 32'h0002);
        wait_empty("t5b_empty");

        // 6a: reset while fill owns memory drops the grant at once
        enter_fill(16'h0800);
        do_store(16'h0070, 16'h7070);
        sb.fill_req = 1'b0;
        rst = 1'b1;
        #1;
        check("t6a_gnt_async", 32'(sb.fill_gnt), 32'd0);
        check("t6a_count_async", 32'(sb.count), 32'd0);
        tick();
        rst = 1'b0;

        // 6b: reset mid-drain with three entries discards them
        enter_fill(16'h0800);
        do_store(16'h0080, 16'h8080);
        do_store(16'h0082, 16'h8282);
        do_store(16'h0084, 16'h8484);
        release_fill();
        t = 0;
        while (sb.mem_en !== 1'b1 && t < 20) begin
            tick();
            t++;
        end
        check("t6b_count_pre", 32'(sb.count), 32'd3);
        rst = 1'b1;
        #1;
        check("t6b_count_async", 32'(sb.count), 32'd0);
        check("t6b_empty_async", 32'(sb.empty), 32'd1);
        check("t6b_mem_en_async", 32'(sb.mem_en), 32'd0);
        check("t6b_gnt_async", 32'(sb.fill_gnt), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        repeat (10) tick();
        check("t6b_no_writes", 32'(exp_q.size()), 32'd0);
        check("t6b_empty_after", 32'(sb.empty), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
